// File: rtl/mem_arb_pkg.sv
// Shared encodings, response-pipeline payload and byte-enable helper for the
// unified-memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef struct packed {
        logic       valid;
        owner_e     owner;
        logic [1:0] size;
        logic       sign_ext;
        logic [1:0] lane;
        logic       store;
        logic       err;
    } rsp_pipe_t;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: return 4'b1111;
            SZ_HALF: return 4'b0011 << lane;
            SZ_BYTE: return 4'b0001 << lane;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic size_legal(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_WORD: return (lane == 2'b00);
            SZ_HALF: return !lane[0];
            SZ_BYTE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load-lane extraction: shift the read word down to the
// addressed lane, then sign- or zero-extend according to the access size.
module load_align
    import mem_arb_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_size,
    input  logic        i_sign_ext,
    input  logic [1:0]  i_lane,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_lane, 3'b000};

    always_comb begin
        o_data = w_shifted;
        case (i_size)
            SZ_HALF: o_data = {{16{i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
            SZ_BYTE: o_data = {{24{i_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port unified-memory arbiter: one grant per cycle between fetch and
// load/store, data-region offset, alignment checks and fetch anti-starvation.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] DATA_BASE    = ADDR_W'(100),
    parameter int unsigned       STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_rsp_valid,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_err,
    input  logic              d_req_valid,
    input  logic              d_req_write,
    input  logic [1:0]        d_req_size,
    input  logic              d_req_signed,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [31:0]       d_rsp_data,
    output logic              d_rsp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);
    localparam logic [3:0] LP_STARVE_MAX   = 4'd15;

    logic [3:0]        r_starve_cnt;
    rsp_pipe_t         r_rsp;
    logic              w_if_grant;
    logic              w_d_grant;
    logic              w_store;
    logic              w_err;
    logic              w_issue;
    logic [ADDR_W-1:0] w_ea;
    logic [1:0]        w_lane;
    logic [1:0]        w_size;
    logic [31:0]       w_load_data;
    logic [31:0]       w_rsp_data;

    // Data normally wins; a fetch that has lost STARVE_LIMIT cycles in a row takes over.
    assign w_if_grant = !rst && if_req_valid &&
                        (!d_req_valid || (r_starve_cnt >= LP_STARVE_LIMIT));
    assign w_d_grant  = !rst && d_req_valid && !w_if_grant;

    assign if_req_ready = w_if_grant;
    assign d_req_ready  = w_d_grant;

    assign w_ea    = w_d_grant ? ADDR_W'(d_req_addr + DATA_BASE) : if_req_addr;
    assign w_lane  = w_ea[1:0];
    assign w_size  = w_d_grant ? d_req_size : SZ_WORD;
    assign w_store = w_d_grant && d_req_write;
    assign w_err   = !size_legal(w_size, w_lane);
    assign w_issue = (w_if_grant || w_d_grant) && !w_err;

    // Illegal grants still consume the slot but never touch the memory.
    always_comb begin
        mem_en    = w_issue;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_issue) begin
            mem_addr = {w_ea[ADDR_W-1:2], 2'b00};
            if (w_store) begin
                mem_we    = 1'b1;
                mem_be    = be_gen(w_size, w_lane);
                mem_wdata = d_req_wdata << {w_lane, 3'b000};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!if_req_valid || w_if_grant) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != LP_STARVE_MAX) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp <= '0;
        end else begin
            r_rsp.valid    <= w_if_grant || w_d_grant;
            r_rsp.owner    <= w_d_grant ? OWN_D : OWN_IF;
            r_rsp.size     <= w_size;
            r_rsp.sign_ext <= w_d_grant && d_req_signed;
            r_rsp.lane     <= w_lane;
            r_rsp.store    <= w_store;
            r_rsp.err      <= w_err;
        end
    end

    load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_size     (r_rsp.size),
        .i_sign_ext (r_rsp.sign_ext),
        .i_lane     (r_rsp.lane),
        .o_data     (w_load_data)
    );

    assign w_rsp_data   = (r_rsp.err || r_rsp.store) ? 32'd0 : w_load_data;
    assign if_rsp_valid = r_rsp.valid && (r_rsp.owner == OWN_IF);
    assign d_rsp_valid  = r_rsp.valid && (r_rsp.owner == OWN_D);
    assign if_rsp_data  = if_rsp_valid ? w_rsp_data : 32'd0;
    assign d_rsp_data   = d_rsp_valid ? w_rsp_data : 32'd0;
    assign if_rsp_err   = if_rsp_valid && r_rsp.err;
    assign d_rsp_err    = d_rsp_valid && r_rsp.err;

endmodule
